// File: rtl/ppu_types_pkg.sv
// Shared PPU types for the background fetcher: FSM state encoding, VRAM map/data bases
// and the pixel record pushed into the BG FIFO.
package ppu_types_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MAP_REQ = 3'd1,
    MAP_RD  = 3'd2,
    LO_REQ  = 3'd3,
    LO_RD   = 3'd4,
    HI_REQ  = 3'd5,
    HI_RD   = 3'd6,
    PUSH    = 3'd7
  } bg_fetch_state_t;

  localparam logic [15:0] BG_MAP0_BASE   = 16'h9800;
  localparam logic [15:0] BG_MAP1_BASE   = 16'h9C00;
  localparam logic [15:0] TILE_DATA_8000 = 16'h8000;
  localparam logic [15:0] TILE_DATA_9000 = 16'h9000;
  localparam logic [15:0] TILE_BYTES     = 16'd16;

  typedef struct packed {
    logic [2:0] palette;
    logic       bg_prio;
    logic [1:0] color;
  } pixel_t;

  // Pixel p of a tile row comes from bit 7-p of each bitplane (leftmost pixel first).
  function automatic logic [1:0] pixel_color(input logic [7:0] lo, input logic [7:0] hi,
                                             input logic [2:0] p);
    logic [2:0] bit_idx;
    bit_idx = 3'd7 - p;
    return {hi[bit_idx], lo[bit_idx]};
  endfunction

endpackage

// File: rtl/bg_fetch_addr_gen.sv
// Combinational VRAM address generator for the BG fetcher: tile-map byte address and
// low/high bitplane addresses, selected by the current fetch state.
module bg_fetch_addr_gen
  import ppu_types_pkg::*;
#(
  parameter int MAP_WIDTH = 32
) (
  input  logic [7:0]      lcdc,
  input  logic [7:0]      scx,
  input  logic [7:0]      scy,
  input  logic [7:0]      ly,
  input  logic [4:0]      tile_x,
  input  logic [7:0]      tile_id,
  input  bg_fetch_state_t state,
  output logic [15:0]     vram_addr
);

  logic [7:0]  yy_s;
  logic [5:0]  col_sum_s;
  logic [4:0]  map_col_s;
  logic [15:0] map_base_s;
  logic [15:0] map_addr_s;
  logic [15:0] row_addr_s;
  logic [15:0] lo_addr_s;
  logic        unused_s;

  assign unused_s = ^{lcdc[7:5], lcdc[2:0], scx[2:0]};

  // Map and bitplane address arithmetic; all 8-bit sums wrap naturally.
  always_comb begin
    yy_s       = scy + ly;
    col_sum_s  = {1'b0, scx[7:3]} + {1'b0, tile_x};
    map_col_s  = 5'(col_sum_s % 6'(MAP_WIDTH));
    map_base_s = lcdc[3] ? BG_MAP1_BASE : BG_MAP0_BASE;
    map_addr_s = map_base_s + {6'b0, yy_s[7:3], 5'b0} + {11'b0, map_col_s};
    // 8000 mode indexes tiles unsigned, 9000 mode treats the id as signed.
    if (lcdc[4]) begin
      row_addr_s = TILE_DATA_8000 + ({8'h00, tile_id} * TILE_BYTES);
    end else begin
      row_addr_s = TILE_DATA_9000 + ({{8{tile_id[7]}}, tile_id} * TILE_BYTES);
    end
    lo_addr_s = row_addr_s + {12'b0, yy_s[2:0], 1'b0};
  end

  // Pick the address for the byte the current state is fetching.
  always_comb begin
    case (state)
      MAP_REQ, MAP_RD: vram_addr = map_addr_s;
      LO_REQ, LO_RD:   vram_addr = lo_addr_s;
      HI_REQ, HI_RD:   vram_addr = lo_addr_s + 16'd1;
      default:         vram_addr = 16'h0000;
    endcase
  end

endmodule

// File: rtl/bg_pixel_fetcher.sv
// PPU mode-3 background fetcher: fetches map byte and two bitplanes per tile from VRAM,
// then pushes eight pixels into the BG FIFO, honouring FIFO backpressure.
module bg_pixel_fetcher
  import ppu_types_pkg::*;
#(
  parameter int TILES_PER_LINE = 21,
  parameter int MAP_WIDTH      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        vram_read_req,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_rdata,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  output logic        write_en,
  output logic [5:0]  write_data,
  input  logic        full,
  input  logic        empty,
  output logic        busy,
  output logic        done,
  output logic [4:0]  tile_x
);

  localparam logic [4:0] LAST_TILE = 5'(TILES_PER_LINE - 1);

  bg_fetch_state_t state_r, next_state_s;
  logic [2:0]  p_r;
  logic [4:0]  tile_x_r;
  logic [7:0]  tile_id_r, lo_r, hi_r;
  logic [15:0] addr_r, gen_addr_s;
  logic        done_r;
  logic        last_push_s;
  pixel_t      pixel_s;
  logic        unused_s;

  assign unused_s    = empty;
  assign last_push_s = (state_r == PUSH) && !full && (p_r == 3'd7);

  bg_fetch_addr_gen #(.MAP_WIDTH(MAP_WIDTH)) u_addr_gen (
    .lcdc      (lcdc),
    .scx       (scx),
    .scy       (scy),
    .ly        (ly),
    .tile_x    (tile_x_r),
    .tile_id   (tile_id_r),
    .state     (state_r),
    .vram_addr (gen_addr_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    next_state_s = state_r;
    if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = start ? MAP_REQ : IDLE;
        MAP_REQ: next_state_s = MAP_RD;
        MAP_RD:  next_state_s = LO_REQ;
        LO_REQ:  next_state_s = LO_RD;
        LO_RD:   next_state_s = HI_REQ;
        HI_REQ:  next_state_s = HI_RD;
        HI_RD:   next_state_s = PUSH;
        PUSH: begin
          if (last_push_s) next_state_s = (tile_x_r == LAST_TILE) ? IDLE : MAP_REQ;
          else             next_state_s = PUSH;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Fetched bytes, held address, pixel counter, tile index and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= 3'd0;
      tile_x_r  <= 5'd0;
      tile_id_r <= 8'h00;
      lo_r      <= 8'h00;
      hi_r      <= 8'h00;
      addr_r    <= 16'h0000;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        p_r      <= 3'd0;
        tile_x_r <= 5'd0;
      end else begin
        case (state_r)
          MAP_REQ, LO_REQ, HI_REQ: addr_r <= gen_addr_s;
          MAP_RD: tile_id_r <= vram_rdata;
          LO_RD:  lo_r      <= vram_rdata;
          HI_RD:  hi_r      <= vram_rdata;
          PUSH: begin
            if (!full) begin
              p_r <= p_r + 3'd1;
              if (p_r == 3'd7) begin
                if (tile_x_r == LAST_TILE) begin
                  tile_x_r <= 5'd0;
                  done_r   <= 1'b1;
                end else begin
                  tile_x_r <= tile_x_r + 5'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode; RD cycles replay the address captured during the request.
  always_comb begin
    vram_read_req   = 1'b0;
    vram_addr       = 16'h0000;
    write_en        = 1'b0;
    pixel_s         = '0;
    case (state_r)
      MAP_REQ, LO_REQ, HI_REQ: begin
        vram_read_req = 1'b1;
        vram_addr     = gen_addr_s;
      end
      MAP_RD, LO_RD, HI_RD: vram_addr = addr_r;
      PUSH: begin
        write_en      = !full && !abort;
        pixel_s.color = pixel_color(lo_r, hi_r, p_r);
      end
      default: ;
    endcase
    write_data = pixel_s;
    busy       = (state_r != IDLE);
    done       = done_r;
    tile_x     = tile_x_r;
  end

endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Directed self-checking bench for bg_pixel_fetcher: table-driven single-tile vectors
// plus hand sequences for reset, backpressure, full-line timing and abort.
module tb_bg_pixel_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, full = 1'b0, empty = 1'b1;
  logic        vram_read_req, write_en, busy, done;
  logic [15:0] vram_addr;
  logic [7:0]  vram_rdata = 8'h00;
  logic [7:0]  lcdc = 8'h00, scx = 8'h00, scy = 8'h00, ly = 8'h00;
  logic [5:0]  write_data;
  logic [4:0]  tile_x;

  int n_vec = 0;
  int n_fail = 0;

  bg_pixel_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vram_read_req(vram_read_req), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .lcdc(lcdc), .scx(scx), .scy(scy), .ly(ly),
    .write_en(write_en), .write_data(write_data), .full(full), .empty(empty),
    .busy(busy), .done(done), .tile_x(tile_x)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  lcdc, scx, scy, ly, tile_id, lo, hi;
    logic [15:0] map_a, lo_a, hi_a, map_next, colors;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int cyc, pushes, stall, done_cnt, done_cyc;

    vecs[0] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA0, 8'hC0,
                16'h9800, 16'h8050, 16'h8051, 16'h9801, 16'hE400};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h00,
                16'h9800, 16'h8800, 16'h8801, 16'h9801, 16'h5555};
    vecs[2] = '{8'h10, 8'hF8, 8'h00, 8'h09, 8'h01, 8'h00, 8'hFF,
                16'h983F, 16'h8012, 16'h8013, 16'h9820, 16'hAAAA};
    vecs[3] = '{8'h08, 8'h10, 8'hFE, 8'h03, 8'h7F, 8'h0F, 8'h33,
                16'h9C02, 16'h97F2, 16'h97F3, 16'h9C03, 16'h0A5F};

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req", 32'(vram_read_req), 32'd0);
    chk("reset_addr", 32'(vram_addr), 32'd0);
    chk("reset_wdata", 32'(write_data), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      lcdc = vecs[i].lcdc; scx = vecs[i].scx; scy = vecs[i].scy; ly = vecs[i].ly;
      start = 1'b1; tick(); start = 1'b0;
      chk("map_req", 32'(vram_read_req), 32'd1);
      chk("map_addr", 32'(vram_addr), 32'(vecs[i].map_a));
      tick();
      chk("map_rd_req", 32'(vram_read_req), 32'd0);
      chk("map_rd_addr", 32'(vram_addr), 32'(vecs[i].map_a));
      vram_rdata = vecs[i].tile_id; tick();
      chk("lo_addr", 32'(vram_addr), 32'(vecs[i].lo_a));
      tick();
      vram_rdata = vecs[i].lo; tick();
      chk("hi_addr", 32'(vram_addr), 32'(vecs[i].hi_a));
      tick();
      vram_rdata = vecs[i].hi; tick();
      for (int p = 0; p < 8; p++) begin
        chk("push_we", 32'(write_en), 32'd1);
        chk("push_color", 32'(write_data[1:0]), 32'(vecs[i].colors[15-2*p -: 2]));
        tick();
      end
      chk("next_map_addr", 32'(vram_addr), 32'(vecs[i].map_next));
      chk("next_tile_x", 32'(tile_x), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tile_x", 32'(tile_x), 32'd0);
    end

    // Backpressure: FIFO full for 5 cycles once three pixels are in.
    lcdc = 8'h10; scx = 8'h00; scy = 8'h00; ly = 8'h00; vram_rdata = 8'h10;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0; pushes = 0; stall = 0;
    while (pushes < 8 && cyc < 100) begin
      full = (pushes == 3) && (stall < 5);
      #1;
      if (full) begin
        stall++;
        chk("stall_we", 32'(write_en), 32'd0);
      end else if (write_en) begin
        chk("bp_color", 32'(write_data[1:0]), (pushes == 3) ? 32'd3 : 32'd0);
        pushes++;
      end
      cyc++;
      tick();
    end
    full = 1'b0;
    chk("bp_pushes", 32'(pushes), 32'd8);
    chk("bp_cycles", 32'(cyc), 32'd19);
    chk("bp_next_tile", 32'(tile_x), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Full scanline with no backpressure.
    vram_rdata = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0; pushes = 0; done_cnt = 0; done_cyc = 0;
    while (cyc < 300) begin
      if (write_en) pushes++;
      tick();
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    chk("line_pushes", 32'(pushes), 32'd168);
    chk("line_done_cnt", 32'(done_cnt), 32'd1);
    chk("line_done_cyc", 32'(done_cyc), 32'd294);
    chk("line_idle", 32'(busy), 32'd0);

    // Abort while the low bitplane read is in flight.
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_lo_busy", 32'(busy), 32'd0);
    chk("abort_lo_req", 32'(vram_read_req), 32'd0);
    pushes = 0;
    for (int k = 0; k < 30; k++) begin
      if (write_en) pushes++;
      tick();
    end
    chk("abort_no_push", 32'(pushes), 32'd0);

    // Reset in the middle of pushing clears outputs immediately.
    vram_rdata = 8'hFF;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_we", 32'(write_en), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    chk("rst_tile_x", 32'(tile_x), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    stall = 0;
    for (int k = 0; k < 10; k++) begin
      if (vram_read_req) stall++;
      tick();
    end
    chk("post_rst_no_req", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
